uart_rx_monitor: RTL and testbench



---
 rtl/uart_sim_pkg.sv | 19 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_rx_monitor.sv | 144 ++++++++++++++
 tb/tb_uart_rx_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sim_pkg.sv
// Shared definitions for the simulation-side UART blocks.
//   rx_state_e   : receive frame FSM state encoding
//   clks_per_bit : rounded number of system clocks per serial bit
package uart_sim_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i : write request and data; ignored when full unless popping the same cycle
//   pop_i         : read request; ignored when empty
//   head_o        : byte at the head, 0 when empty
//   full_o/empty_o/level_o : status, level_o reaches Depth when full
// Depth must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0]      mem [Depth];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [$clog2(Depth):0] level_q, level_d;
    logic                  do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == ($clog2(Depth) + 1)'(Depth));
    assign level_o = level_q;
    assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for simulation, buffering decoded bytes in a FIFO.
//   clk, rstn  : clock, synchronous active-low reset
//   rxd        : serial input, idle high
//   out_data/out_valid/out_ready : FIFO head port, out_data is 0 when empty
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overflow   : sticky, set when a byte is dropped into a full FIFO
//   level      : FIFO fill count
module uart_rx_monitor
    import uart_sim_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 28375160,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rxd,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned N    = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned H    = N / 2;
    localparam int unsigned CntW = $clog2(N);

    logic            rxd_meta_q, rxd_s_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            ferr_q, ferr_d;
    logic            overflow_q;
    logic            fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxd_s_q) begin
                    state_d = StStart;
                    cnt_d   = CntW'(H - 1);
                end
            end
            StStart: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxd_s_q) begin
                    state_d = StData;
                    cnt_d   = CntW'(N - 1);
                    idx_d   = '0;
                end else begin
                    // Start bit gone by mid-bit: treat as a glitch.
                    state_d = StIdle;
                end
            end
            StData: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    cnt_d   = CntW'(N - 1);
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxd_s_q) begin
                    push_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = StBreak;
                end
            end
            StBreak: begin
                // Hold here while the line stays low so a break yields no bytes.
                if (rxd_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !(out_valid && out_ready)) begin
            overflow_q <= 1'b1;
        end
    end

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (out_ready),
        .head_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = !fifo_empty;
    assign frame_err = ferr_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: a per-cycle FIFO model fed by frame timing
// computed from the bit period, plus fixed expectations for each scenario.
module tb_uart_rx_monitor;

    localparam int unsigned CLK_HZ = 28375160;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned DEPTH  = 16;
    localparam int N  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int H  = N / 2;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rxd;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] level;

    uart_rx_monitor #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [7:0] data;
    } push_ev_t;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    push_ev_t   push_evq[$];
    int         ferr_evq[$];
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] popped[$];
    int         ferr_cnt = 0;
    int         rise_edge = -1;
    int         last_t0 = 0;
    logic       prev_valid = 1'b0;
    logic       rand_ready = 1'b0;

    logic [7:0] diag [9] = '{8'h44, 8'h69, 8'h61, 8'h67, 8'h52, 8'h4F, 8'h4D, 8'h0D, 8'h0A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: FIFO as a queue; frame events land on edges derived from t0.
    always @(posedge clk) begin
        logic       pop;
        logic       do_push;
        logic [7:0] pd;
        cyc++;
        pd = 8'h00;
        if (!rstn) begin
            mq.delete();
            push_evq.delete();
            ferr_evq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            pop    = (mq.size() > 0) && out_ready;
            m_ferr = 1'b0;
            while (ferr_evq.size() > 0 && ferr_evq[0] == cyc) begin
                m_ferr = 1'b1;
                void'(ferr_evq.pop_front());
            end
            do_push = 1'b0;
            if (push_evq.size() > 0 && push_evq[0].edge_no == cyc) begin
                do_push = 1'b1;
                pd      = push_evq[0].data;
                void'(push_evq.pop_front());
            end
            if (pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(pd);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the reference, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("out_data", 32'(out_data), 32'(mq.size() > 0 ? mq[0] : 8'h00));
            check("level", 32'(level), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            if (out_valid && out_ready) popped.push_back(out_data);
            if (frame_err) ferr_cnt++;
            if (out_valid && !prev_valid && rise_edge < 0) rise_edge = cyc + 1;
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        int t0;
        t0 = cyc + 1;
        last_t0 = t0;
        if (stop_bit) push_evq.push_back(push_ev_t'{t0 + 3 + H + 9 * N, d});
        else ferr_evq.push_back(t0 + 2 + H + 9 * N);
        rxd = 1'b0;
        wait_n(N);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_n(N);
        end
        rxd = stop_bit;
        wait_n(N);
        rxd = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected test end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0;
        logic [7:0] d;
        logic sb;
        rxd       = 1'b1;
        rstn      = 1'b0;
        out_ready = 1'b0;
        wait_n(3);
        check_reset_outputs("rst");
        rstn = 1'b1;
        wait_n(5);

        // Single byte, consumer stalled: latency and contents.
        ferr0 = ferr_cnt;
        rise_edge = -1;
        send_frame(8'h55, 1'b1);
        wait_n(20);
        check("t1_latency", 32'(rise_edge - last_t0), 32'(4 + H + 9 * N));
        check("t1_data", 32'(out_data), 32'h55);
        check("t1_level", 32'(level), 32'd1);
        check("t1_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // Reset during data bit 3 with a byte still buffered.
        rxd = 1'b0;
        wait_n(N);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b0;
            wait_n(N);
        end
        rxd = 1'b1;
        wait_n(N / 2);
        rstn = 1'b0;
        wait_n(1);
        rstn = 1'b1;
        check_reset_outputs("midrst");
        wait_n(2 * N);
        send_frame(8'hA5, 1'b1);
        wait_n(20);
        check("a5_level", 32'(level), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        wait_n(3);

        // Back-to-back string, consumer always ready.
        popped.delete();
        for (int i = 0; i < 9; i++) send_frame(diag[i], 1'b1);
        wait_n(20);
        check("diag_count", 32'(popped.size()), 32'd9);
        for (int i = 0; i < 9; i++) check("diag_byte", 32'(popped[i]), 32'(diag[i]));
        check("diag_ovf", 32'(overflow), 32'd0);

        // Short low glitch: no byte, no framing error.
        ferr0 = ferr_cnt;
        popped.delete();
        rxd = 1'b0;
        wait_n(50);
        rxd = 1'b1;
        wait_n(H + 20);
        check("glitch_bytes", 32'(popped.size()), 32'd0);
        check("glitch_level", 32'(level), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // Bad stop bit then a held-low line, then a clean byte.
        out_ready = 1'b0;
        ferr0 = ferr_cnt;
        send_frame(8'h41, 1'b0);
        rxd = 1'b0;
        wait_n(1000);
        rxd = 1'b1;
        wait_n(2 * N);
        send_frame(8'h42, 1'b1);
        wait_n(20);
        check("break_ferr", 32'(ferr_cnt - ferr0), 32'd1);
        check("break_level", 32'(level), 32'd1);
        check("break_data", 32'(out_data), 32'h42);
        out_ready = 1'b1;
        wait_n(3);

        // 17 bytes into a 16-deep FIFO.
        out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        wait_n(20);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        popped.delete();
        out_ready = 1'b1;
        wait_n(20);
        out_ready = 1'b0;
        check("ovf_drain_count", 32'(popped.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("ovf_drain_byte", 32'(popped[i]), 32'(i));
        check("ovf_drained_level", 32'(level), 32'd0);

        // Random bytes, random stop-bit errors, random consumer.
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, sb);
            if (!sb) wait_n(4);
            else wait_n($urandom_range(0, N));
        end
        wait_n(20);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_n(20);

        // Reset clears the sticky overflow flag.
        rstn = 1'b0;
        wait_n(1);
        rstn = 1'b1;
        check_reset_outputs("endrst");
        wait_n(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
